dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Memory-side responder for the processor's load/store port: answers word accesses issued on
//   aluout/writedata/readdata with a req/ready handshake and a programmable number of wait states.
// - Sits between the datapath and the data RAM array; it is instanced in the multi-cycle/stalling
//   top level in place of a zero-latency dmem, and the controller stalls on !ready.
// - Word-addressed storage is held internally; misaligned and out-of-range accesses are flagged.
// PARAMETERS
// - DEPTH_WORDS  64      number of 32-bit words; must be a power of 2, >= 4
// - WAIT_STATES  2       idle cycles between acceptance and response, 0..15
// - BASE_ADDR    32'h0   byte address of word 0; must be aligned to DEPTH_WORDS*4
// PORTS
// - clk    in   1   rising-edge clock
// - reset  in   1   asynchronous reset, active-low (asserted when 0)
// - req    in   1   access request; held high by the requester until ready
// - we     in   1   1 = store, 0 = load; sampled at acceptance
// - addr   in   32  byte address (aluout); sampled at acceptance
// - wdata  in   32  store data (writedata); sampled at acceptance
// - be     in   4   byte enables, bit i -> wdata[8i+7:8i] (present only with DMEM_BYTE_EN_EN)
// - rdata  out  32  load data (readdata); valid when ready=1 and err=0
// - ready  out  1   one-cycle pulse: access complete
// - err    out  1   qualifies ready: access rejected (misaligned or out of range)
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
//   RAM contents are NOT cleared.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: if req=1, latch we/addr/wdata(/be); go to WAIT with cnt=WAIT_STATES-1.
//     If WAIT_STATES=0, go directly to RESP.
//   - WAIT: cnt decrements each cycle; at cnt=0 go to RESP.
//   - RESP: ready=1 for exactly this cycle; go to IDLE.
// - Latency: ready asserts WAIT_STATES+1 cycles after the acceptance edge.
// - No back-to-back acceptance: req high during RESP is ignored; the next access is accepted in the
//   following IDLE cycle (min 2 cycles per access at WAIT_STATES=0).
// - Changes on addr/we/wdata after acceptance are ignored (latched copies are used).
// - Index = (addr - BASE_ADDR) >> 2. Error if addr[1:0]!=0 or addr outside
//   [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4-1].
//   - On error: no RAM write, rdata=0, err=1 with ready.
// - Store: RAM word written on the RESP clock edge; rdata unchanged by stores.
// - Load: rdata registered with mem[index], valid in the RESP cycle and held until the next load
//   response or reset. err=0 whenever ready=0.
// - Reset mid-access (in WAIT or RESP): access aborted; no write, no ready pulse, back to IDLE.
// CONFIGURATION
// - DMEM_BYTE_EN_EN defined: be port exists. Store updates only bytes with be[i]=1; be=4'b0000 is a
//   legal no-op store (ready, err=0). Loads ignore be.
// - DMEM_BYTE_EN_EN undefined: no be port; every store writes the full 32-bit word.
// TESTING
// - Reset, then idle 5 cycles -> ready=0, err=0, rdata=0 throughout.
// - WAIT_STATES=2: store addr=0x10, wdata=0xDEADBEEF, then load 0x10 -> each ready exactly 3 cycles
//   after acceptance; load rdata=0xDEADBEEF.
// - Load addr=0x12 (misaligned) and load addr=0x100 (DEPTH_WORDS=64) -> ready=1, err=1, rdata=0;
//   word 0x10 still reads 0xDEADBEEF.
// - req held high continuously, WAIT_STATES=0 -> ready every 2nd cycle, no missed or duplicate
//   accesses.
// - Store to 0x20 with reset pulsed low during WAIT -> no ready; later load 0x20 returns prior contents.
// - DMEM_BYTE_EN_EN: word 0x20=0x11223344; store wdata=0xAABBCCDD, be=4'b0101 -> load 0x20
//   returns 0x11BB33DD.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering the load/store port through a
// req/ready handshake with WAIT_STATES wait cycles between acceptance and response.
// Misaligned or out-of-range accesses complete with err=1, rdata=0 and no RAM write.
// Optional feature: define DMEM_BYTE_EN_EN to add the be port (per-byte store enables).
//
// Handshake: the requester raises req and holds it, with we/addr/wdata(/be) stable,
// until it sees ready. The access is accepted on the first rising edge where the
// responder is IDLE and req=1; the request fields are captured on that edge and later
// changes are ignored. ready is a single-cycle pulse; err is only ever high together
// with ready. The next access can be accepted at the earliest in the cycle after ready.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be_q, be_d;
`endif

  logic [31:0]      mem_q [DEPTH_WORDS];

  // In IDLE the access being decided is the one on the inputs; afterwards it is the
  // captured copy. This lets a zero-wait access go IDLE->RESP with correct rdata.
  logic [31:0]      cur_addr;
  logic             cur_we;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic             mem_wr;

  assign cur_addr = (state_q == ST_IDLE) ? addr : addr_q;
  assign cur_we   = (state_q == ST_IDLE) ? we : we_q;
  // BASE_ADDR is aligned to the array size, so the range test is a compare of the
  // upper address bits and the word index is simply the bits just above the byte offset.
  assign cur_err  = (cur_addr[1:0] != 2'b00) ||
                    (cur_addr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2]);
  assign cur_idx  = cur_addr[IDX_W+1:2];
  assign mem_wr   = (state_q == ST_RESP) && we_q && !cur_err;

  assign rdata     = rdata_q;
  assign ready     = (state_q == ST_RESP);
  assign err       = (state_q == ST_RESP) && cur_err;
  assign state_dbg = state_q;

  // Next-state, request capture and load-data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DMEM_BYTE_EN_EN
    be_d    = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef DMEM_BYTE_EN_EN
          be_d    = be;
`endif
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // rdata is loaded on the edge that enters RESP; stores leave it untouched.
    if (state_d == ST_RESP) begin
      if (cur_err) begin
        rdata_d = 32'h0;
      end else if (!cur_we) begin
        rdata_d = mem_q[cur_idx];
      end
    end
  end

  // Control and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= be_d;
`endif
    end
  end

  // RAM array: written on the RESP edge of a valid store; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[cur_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem_q[cur_idx] <= wdata_q;
`endif
    end
  end

endmodule
